// File: rtl/mem_pkg.sv
// Shared definitions for the unified-RAM arbiter and its helpers.
//   - requester identifiers used by the read-response pipeline
//   - store-size encodings carried on d_wsize
//   - address widths of the 16 KB RAM (byte and word)
package mem_pkg;

   typedef enum logic [1:0] {
      REQ_IF = 2'd0,
      REQ_D  = 2'd1,
      REQ_RK = 2'd2
   } req_id_e;

   localparam logic [1:0] SZ_B = 2'b01;
   localparam logic [1:0] SZ_H = 2'b10;
   localparam logic [1:0] SZ_W = 2'b11;

   localparam int unsigned MEM_AW  = 14;
   localparam int unsigned MEM_WAW = MEM_AW - 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the unified-RAM arbiter: IF fetch port, D load/store
// port and RK loader port.
//   slave  : arbiter side (takes requests, returns gnt/rvalid/rdata/err)
//   master : requester side
interface mem_arbiter_if #(
   parameter int AW = mem_pkg::MEM_AW
) ();

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [31:0]   if_rdata;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [1:0]    d_wsize;
   logic [31:0]   d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [31:0]   d_rdata;
   logic          d_err;

   logic          rk_req;
   logic          rk_we;
   logic [AW-1:0] rk_addr;
   logic [31:0]   rk_wdata;
   logic          rk_lock;
   logic          rk_gnt;
   logic          rk_rvalid;
   logic [31:0]   rk_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_wsize, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_err,
      input  rk_req, rk_we, rk_addr, rk_wdata, rk_lock,
      output rk_gnt, rk_rvalid, rk_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_wsize, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      output rk_req, rk_we, rk_addr, rk_wdata, rk_lock,
      input  rk_gnt, rk_rvalid, rk_rdata
   );

endinterface

// File: rtl/mem_lane_steer.sv
// Byte-lane steering for a 32-bit word RAM (purely combinational).
//   we_i, wsize_i, off_i, wdata_i : store request (right-justified data)
//   wstrb_o, wdata_o              : byte strobes and lane-replicated data
//   misalign_o                    : store cannot be performed (bad size/offset)
//   roff_i, rword_i, rdata_o      : read word right-justified by roff_i bytes
module mem_lane_steer (
   input  logic        we_i,
   input  logic [1:0]  wsize_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic        misalign_o,
   input  logic [1:0]  roff_i,
   input  logic [31:0] rword_i,
   output logic [31:0] rdata_o
);
   import mem_pkg::*;

   logic [3:0] strb;
   logic       bad;

   always_comb begin
      strb    = 4'b0000;
      wdata_o = wdata_i;
      bad     = 1'b0;
      case (wsize_i)
         SZ_B: begin
            strb    = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         SZ_H: begin
            strb    = 4'b0011 << off_i;
            wdata_o = {2{wdata_i[15:0]}};
            bad     = off_i[0];
         end
         SZ_W: begin
            strb = 4'b1111;
            bad  = |off_i;
         end
         default: bad = 1'b1;
      endcase
      misalign_o = we_i && bad;
      wstrb_o    = (we_i && !bad) ? strb : 4'b0000;
   end

   // Zero-filled right shift: a misaligned read never reaches the next word.
   assign rdata_o = rword_i >> {roff_i, 3'b000};

endmodule

// File: rtl/mem_arbiter.sv
// Three-way arbiter in front of a single-port word RAM (1-cycle read latency).
//   clk, resetn : clock, synchronous active-low reset
//   bus         : requester ports IF / D / RK (mem_arbiter_if.slave)
//   m_*         : RAM macro port; m_rdata returns one cycle after m_en
// Grants are combinational in the request cycle; rvalid/rdata follow one
// cycle later. IF and RK have bounded-wait promotion, RK can lock bursts.
module mem_arbiter #(
   parameter int WAIT_MAX = 8,
   parameter int LOCK_MAX = 16,
   parameter int AW       = mem_pkg::MEM_AW
) (
   input  logic          clk,
   input  logic          resetn,
   mem_arbiter_if.slave  bus,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-3:0] m_addr,
   output logic [3:0]    m_wstrb,
   output logic [31:0]   m_wdata,
   input  logic [31:0]   m_rdata
);
   import mem_pkg::*;

   localparam int WCW = $clog2(WAIT_MAX + 1);
   localparam int BCW = $clog2(LOCK_MAX + 1);

   logic [WCW-1:0] if_wait_q, if_wait_d, rk_wait_q, rk_wait_d;
   logic           lock_q, lock_d;
   logic [BCW-1:0] beat_q, beat_d;
   logic           rsp_vld_q, rsp_vld_d;
   req_id_e        rsp_own_q, rsp_own_d;
   logic [1:0]     rsp_off_q, rsp_off_d;
   logic           err_q, err_d;

   logic           gnt_if, gnt_d, gnt_rk;
   logic           if_prom, rk_prom;
   logic [3:0]     d_wstrb;
   logic [31:0]    d_wdata_st, d_rdata_st;
   logic           d_bad;
   logic           unused_addr_bits;

   // IF and RK are word-only; their byte offset is deliberately dropped.
   assign unused_addr_bits = ^{bus.if_addr[1:0], bus.rk_addr[1:0]};

   mem_lane_steer u_steer (
      .we_i       (bus.d_we),
      .wsize_i    (bus.d_wsize),
      .off_i      (bus.d_addr[1:0]),
      .wdata_i    (bus.d_wdata),
      .wstrb_o    (d_wstrb),
      .wdata_o    (d_wdata_st),
      .misalign_o (d_bad),
      .roff_i     (rsp_off_q),
      .rword_i    (m_rdata),
      .rdata_o    (d_rdata_st)
   );

   // Promotion needs a live request: the counter still reads WAIT_MAX in
   // the cycle a requester withdraws.
   always_comb begin
      if_prom = bus.if_req && (if_wait_q == WCW'(WAIT_MAX));
      rk_prom = bus.rk_req && (rk_wait_q == WCW'(WAIT_MAX));
      gnt_if  = 1'b0;
      gnt_d   = 1'b0;
      gnt_rk  = 1'b0;
      if (lock_q && bus.rk_req) gnt_rk = 1'b1;
      else if (rk_prom)         gnt_rk = 1'b1;
      else if (if_prom)         gnt_if = 1'b1;
      else if (bus.d_req)       gnt_d  = 1'b1;
      else if (bus.rk_req)      gnt_rk = 1'b1;
      else if (bus.if_req)      gnt_if = 1'b1;
   end

   // A rejected D store is still granted but never reaches the RAM.
   always_comb begin
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wstrb = 4'b0000;
      m_wdata = '0;
      if (gnt_if) begin
         m_en   = 1'b1;
         m_addr = bus.if_addr[AW-1:2];
      end else if (gnt_rk) begin
         m_en    = 1'b1;
         m_we    = bus.rk_we;
         m_addr  = bus.rk_addr[AW-1:2];
         m_wstrb = bus.rk_we ? 4'b1111 : 4'b0000;
         m_wdata = bus.rk_wdata;
      end else if (gnt_d) begin
         m_en    = !d_bad;
         m_we    = bus.d_we && !d_bad;
         m_addr  = bus.d_addr[AW-1:2];
         m_wstrb = d_wstrb;
         m_wdata = d_wdata_st;
      end
   end

   always_comb begin
      if_wait_d = if_wait_q;
      if (!bus.if_req || gnt_if)               if_wait_d = '0;
      else if (if_wait_q != WCW'(WAIT_MAX))    if_wait_d = if_wait_q + 1'b1;

      rk_wait_d = rk_wait_q;
      if (!bus.rk_req || gnt_rk)               rk_wait_d = '0;
      else if (rk_wait_q != WCW'(WAIT_MAX))    rk_wait_d = rk_wait_q + 1'b1;

      // The LOCK_MAX-th locked beat drops the lock for one arbitration round.
      lock_d = lock_q;
      beat_d = beat_q;
      if (gnt_rk) begin
         if (bus.rk_lock && (beat_q != BCW'(LOCK_MAX - 1))) begin
            lock_d = 1'b1;
            beat_d = beat_q + 1'b1;
         end else begin
            lock_d = 1'b0;
            beat_d = '0;
         end
      end else if (!bus.rk_req) begin
         lock_d = 1'b0;
         beat_d = '0;
      end

      rsp_vld_d = gnt_if || (gnt_rk && !bus.rk_we) || (gnt_d && !bus.d_we);
      rsp_own_d = rsp_own_q;
      rsp_off_d = rsp_off_q;
      if (gnt_rk) begin
         rsp_own_d = REQ_RK;
         rsp_off_d = 2'b00;
      end else if (gnt_d) begin
         rsp_own_d = REQ_D;
         rsp_off_d = bus.d_addr[1:0];
      end else if (gnt_if) begin
         rsp_own_d = REQ_IF;
         rsp_off_d = 2'b00;
      end
      err_d = gnt_d && d_bad;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         if_wait_q <= '0;
         rk_wait_q <= '0;
         lock_q    <= 1'b0;
         beat_q    <= '0;
         rsp_vld_q <= 1'b0;
         rsp_own_q <= REQ_IF;
         rsp_off_q <= 2'b00;
         err_q     <= 1'b0;
      end else begin
         if_wait_q <= if_wait_d;
         rk_wait_q <= rk_wait_d;
         lock_q    <= lock_d;
         beat_q    <= beat_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_own_q <= rsp_own_d;
         rsp_off_q <= rsp_off_d;
         err_q     <= err_d;
      end
   end

   assign bus.if_gnt    = gnt_if;
   assign bus.d_gnt     = gnt_d;
   assign bus.rk_gnt    = gnt_rk;
   assign bus.if_rvalid = rsp_vld_q && (rsp_own_q == REQ_IF);
   assign bus.d_rvalid  = rsp_vld_q && (rsp_own_q == REQ_D);
   assign bus.rk_rvalid = rsp_vld_q && (rsp_own_q == REQ_RK);
   // Read data is held at zero outside its valid cycle.
   assign bus.if_rdata  = bus.if_rvalid ? m_rdata    : '0;
   assign bus.d_rdata   = bus.d_rvalid  ? d_rdata_st : '0;
   assign bus.rk_rdata  = bus.rk_rvalid ? m_rdata    : '0;
   assign bus.d_err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int AW = MEM_AW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               resetn;
   logic               m_en, m_we;
   logic [MEM_WAW-1:0] m_addr;
   logic [3:0]         m_wstrb;
   logic [31:0]        m_wdata, m_rdata;

   mem_arbiter_if #(.AW(AW)) bus ();

   mem_arbiter #(.WAIT_MAX(8), .LOCK_MAX(16), .AW(AW)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .bus     (bus),
      .m_en    (m_en),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wstrb (m_wstrb),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata)
   );

   // RAM macro model and an independent expected-contents copy
   logic [31:0] mem  [0:(1<<MEM_WAW)-1];
   logic [31:0] refm [0:(1<<MEM_WAW)-1];

   always @(posedge clk) begin
      if (m_en) begin
         if (m_we)
            for (int b = 0; b < 4; b++)
               if (m_wstrb[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
         m_rdata <= mem[m_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   typedef struct { logic [31:0] data; int due; } exp_t;
   exp_t q[3][$];   // 0 = IF, 1 = D, 2 = RK

   task automatic push_read(int port, logic [13:0] a);
      exp_t e;
      e.due  = cyc + 1;
      e.data = (port == 1) ? (refm[a[13:2]] >> (8*a[1:0])) : refm[a[13:2]];
      q[port].push_back(e);
   endtask

   // Scoreboard: pop on every rvalid, compare data and one-cycle latency
   always @(negedge clk) begin
      for (int p = 0; p < 3; p++) begin
         logic        v;
         logic [31:0] d;
         exp_t        e;
         v = (p == 0) ? bus.if_rvalid : (p == 1) ? bus.d_rvalid : bus.rk_rvalid;
         d = (p == 0) ? bus.if_rdata  : (p == 1) ? bus.d_rdata  : bus.rk_rdata;
         if (v) begin
            if (q[p].size() == 0) begin
               n_total++;
               $display("FAIL rvalid_unexpected port %0d: got rvalid=1 data %0h, required rvalid=0", p, d);
            end else begin
               e = q[p].pop_front();
               check($sformatf("rdata port %0d", p), d, e.data);
               check($sformatf("rvalid_cycle port %0d", p), cyc, e.due);
            end
         end
      end
   end

   task automatic set_in(logic [2:0] req, logic [13:0] ia, logic [13:0] da, logic [13:0] ra,
                         logic dwe, logic [1:0] sz, logic [31:0] dwd,
                         logic rwe, logic [31:0] rwd, logic rlock);
      bus.if_req   = req[0];  bus.if_addr = ia;
      bus.d_req    = req[1];  bus.d_addr  = da;  bus.d_we = dwe;
      bus.d_wsize  = sz;      bus.d_wdata = dwd;
      bus.rk_req   = req[2];  bus.rk_addr = ra;  bus.rk_we = rwe;
      bus.rk_wdata = rwd;     bus.rk_lock = rlock;
   endtask

   task automatic idle();
      set_in(3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [2:0] req; logic [13:0] ia, da, ra;
      logic dwe; logic [1:0] sz; logic [31:0] dwd; logic rwe; logic [31:0] rwd;
      logic [2:0] eg; logic een, ewe; logic [3:0] es; logic [11:0] ea; logic [31:0] ew; logic eerr;
   } vec_t;

   function automatic vec_t mk(logic [2:0] req, logic [13:0] ia, logic [13:0] da, logic [13:0] ra,
                               logic dwe, logic [1:0] sz, logic [31:0] dwd, logic rwe, logic [31:0] rwd,
                               logic [2:0] eg, logic een, logic ewe, logic [3:0] es,
                               logic [11:0] ea, logic [31:0] ew, logic eerr);
      vec_t v;
      v.req = req; v.ia = ia; v.da = da; v.ra = ra; v.dwe = dwe; v.sz = sz; v.dwd = dwd;
      v.rwe = rwe; v.rwd = rwd; v.eg = eg; v.een = een; v.ewe = ewe; v.es = es;
      v.ea = ea; v.ew = ew; v.eerr = eerr;
      return v;
   endfunction

   vec_t vt[$];
   int   beat;

   initial begin
      for (int i = 0; i < (1<<MEM_WAW); i++) begin
         mem[i]  = (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0000;
         refm[i] = (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0000;
      end
      m_rdata = '0;
      idle();
      resetn = 1'b0;
      step(); step();
      @(negedge clk);
      check("reset_ctl", {bus.if_gnt, bus.d_gnt, bus.rk_gnt, bus.if_rvalid, bus.d_rvalid,
                          bus.rk_rvalid, bus.d_err, m_en, m_we, m_wstrb}, 0);
      check("reset_rdata", bus.if_rdata | bus.d_rdata | bus.rk_rdata, 0);
      step();
      resetn = 1'b1;

      // req = {rk,d,if}; eg = expected {rk_gnt,d_gnt,if_gnt}
      vt.push_back(mk(3'b011, 14'h0000, 14'h0104, 0, 0, 2'b11, 0, 0, 0,             3'b010, 1, 0, 4'b0000, 12'h041, 0, 0));
      vt.push_back(mk(3'b010, 0, 14'h0103, 0, 1, 2'b01, 32'h0000_00AB, 0, 0,          3'b010, 1, 1, 4'b1000, 12'h040, 32'hABAB_ABAB, 0));
      vt.push_back(mk(3'b010, 0, 14'h0103, 0, 0, 2'b01, 0, 0, 0,                      3'b010, 1, 0, 4'b0000, 12'h040, 0, 0));
      vt.push_back(mk(3'b010, 0, 14'h0102, 0, 1, 2'b10, 32'h0000_1234, 0, 0,          3'b010, 1, 1, 4'b1100, 12'h040, 32'h1234_1234, 0));
      vt.push_back(mk(3'b010, 0, 14'h0108, 0, 1, 2'b11, 32'hDEAD_BEEF, 0, 0,          3'b010, 1, 1, 4'b1111, 12'h042, 32'hDEAD_BEEF, 0));
      vt.push_back(mk(3'b010, 0, 14'h0101, 0, 1, 2'b10, 32'h0000_5678, 0, 0,          3'b010, 0, 0, 4'b0000, 12'h040, 0, 1));
      vt.push_back(mk(3'b010, 0, 14'h0102, 0, 1, 2'b11, 32'h0102_0304, 0, 0,          3'b010, 0, 0, 4'b0000, 12'h040, 0, 1));
      vt.push_back(mk(3'b010, 0, 14'h0100, 0, 1, 2'b00, 32'h0000_0099, 0, 0,          3'b010, 0, 0, 4'b0000, 12'h040, 0, 1));
      vt.push_back(mk(3'b010, 0, 14'h0100, 0, 0, 2'b11, 0, 0, 0,                      3'b010, 1, 0, 4'b0000, 12'h040, 0, 0));
      vt.push_back(mk(3'b101, 14'h0000, 0, 14'h0200, 0, 2'b00, 0, 1, 32'hCAFE_F00D,   3'b100, 1, 1, 4'b1111, 12'h080, 32'hCAFE_F00D, 0));
      vt.push_back(mk(3'b101, 14'h0000, 0, 14'h0203, 0, 2'b00, 0, 0, 0,               3'b100, 1, 0, 4'b0000, 12'h080, 0, 0));
      vt.push_back(mk(3'b001, 14'h0106, 0, 0, 0, 2'b00, 0, 0, 0,                      3'b001, 1, 0, 4'b0000, 12'h041, 0, 0));
      vt.push_back(mk(3'b010, 0, 14'h0106, 0, 0, 2'b11, 0, 0, 0,                      3'b010, 1, 0, 4'b0000, 12'h041, 0, 0));
      vt.push_back(mk(3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 0,                             3'b000, 0, 0, 4'b0000, 12'h000, 0, 0));
      vt.push_back(mk(3'b111, 14'h0000, 14'h0108, 14'h0200, 0, 2'b11, 0, 0, 0,        3'b010, 1, 0, 4'b0000, 12'h042, 0, 0));
      vt.push_back(mk(3'b101, 14'h0000, 0, 14'h0108, 0, 2'b00, 0, 0, 0,               3'b100, 1, 0, 4'b0000, 12'h042, 0, 0));
      vt.push_back(mk(3'b010, 0, 14'h0109, 0, 0, 2'b01, 0, 0, 0,                      3'b010, 1, 0, 4'b0000, 12'h042, 0, 0));

      foreach (vt[i]) begin
         vec_t v;
         v = vt[i];
         set_in(v.req, v.ia, v.da, v.ra, v.dwe, v.sz, v.dwd, v.rwe, v.rwd, 1'b0);
         if (v.eg[0])             push_read(0, v.ia);
         if (v.eg[1] && !v.dwe)   push_read(1, v.da);
         if (v.eg[2] && !v.rwe)   push_read(2, v.ra);
         if (v.ewe)
            for (int b = 0; b < 4; b++)
               if (v.es[b]) refm[v.ea][8*b +: 8] = v.ew[8*b +: 8];
         @(negedge clk);
         check($sformatf("v%0d gnt", i), {bus.rk_gnt, bus.d_gnt, bus.if_gnt}, v.eg);
         check($sformatf("v%0d en/we/strb", i), {m_en, m_we, m_wstrb}, {v.een, v.ewe, v.es});
         if (v.een) check($sformatf("v%0d m_addr", i), m_addr, v.ea);
         if (v.ewe) check($sformatf("v%0d m_wdata", i), m_wdata, v.ew);
         step();
         idle();
         @(negedge clk);
         check($sformatf("v%0d d_err", i), bus.d_err, v.eerr);
         step();
      end

      // IF loses to D, then is served while D's read data returns
      set_in(3'b011, 14'h0010, 14'h0104, 0, 0, 2'b11, 0, 0, 0, 0);
      push_read(1, 14'h0104);
      @(negedge clk);
      check("seqA first gnt", {bus.rk_gnt, bus.d_gnt, bus.if_gnt}, 3'b010);
      step();
      set_in(3'b001, 14'h0010, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      push_read(0, 14'h0010);
      @(negedge clk);
      check("seqA second gnt", {bus.rk_gnt, bus.d_gnt, bus.if_gnt}, 3'b001);
      check("seqA d_rvalid", bus.d_rvalid, 1'b1);
      step();
      idle(); step();

      // Bounded wait: IF promoted on cycle 9 and again 9 cycles later
      for (int t = 1; t <= 18; t++) begin
         logic ifw;
         ifw = (t == 9) || (t == 18);
         set_in(3'b011, 14'h0008, 14'h0004, 0, 0, 2'b11, 0, 0, 0, 0);
         if (ifw) push_read(0, 14'h0008);
         else     push_read(1, 14'h0004);
         @(negedge clk);
         check($sformatf("starve t%0d", t), {bus.d_gnt, bus.if_gnt}, {!ifw, ifw});
         step();
      end
      idle(); step();

      // Locked RK burst: 16 beats, forced release serves D, RK resumes
      beat = 0;
      for (int t = 0; t <= 20; t++) begin
         logic dwin;
         logic [13:0] ra;
         dwin = (t == 16);
         ra = 14'h0300 + 14'(4*beat);
         set_in({1'b1, (t >= 1 && t <= 16), 1'b0}, 0, 14'h0104, ra, 0, 2'b11, 0,
                1'b1, 32'hB000_0000 + 32'(beat), 1'b1);
         if (dwin) push_read(1, 14'h0104);
         else begin
            refm[ra[13:2]] = 32'hB000_0000 + 32'(beat);
            beat++;
         end
         @(negedge clk);
         check($sformatf("lock t%0d", t), {bus.rk_gnt, bus.d_gnt}, {!dwin, dwin});
         step();
      end
      idle(); step();
      set_in(3'b100, 0, 0, 14'h034C, 0, 2'b00, 0, 0, 0, 0);
      push_read(2, 14'h034C);
      @(negedge clk);
      check("burst readback gnt", bus.rk_gnt, 1'b1);
      step();
      idle(); step();

      // Reset during a granted, locked RK read
      set_in(3'b100, 0, 0, 14'h0310, 0, 2'b00, 0, 1, 32'h1111_2222, 1);
      refm[14'h0310 >> 2] = 32'h1111_2222;
      @(negedge clk);
      check("rst seq lock gnt", bus.rk_gnt, 1'b1);
      step();
      set_in(3'b100, 0, 0, 14'h0310, 0, 2'b00, 0, 0, 0, 1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      idle();
      @(negedge clk);
      check("rst seq outputs", {bus.if_gnt, bus.d_gnt, bus.rk_gnt, bus.if_rvalid, bus.d_rvalid,
                                bus.rk_rvalid, bus.d_err, m_en, m_we, m_wstrb}, 0);
      check("rst seq rdata", bus.if_rdata | bus.d_rdata | bus.rk_rdata, 0);
      step();
      set_in(3'b110, 0, 14'h0104, 14'h0310, 0, 2'b11, 0, 0, 0, 0);
      push_read(1, 14'h0104);
      @(negedge clk);
      check("rst seq lock clear", {bus.rk_gnt, bus.d_gnt}, 2'b01);
      step();
      set_in(3'b100, 0, 0, 14'h0310, 0, 2'b00, 0, 0, 0, 0);
      push_read(2, 14'h0310);
      @(negedge clk);
      check("rst seq rk regrant", bus.rk_gnt, 1'b1);
      step();
      idle();
      step(); step(); step();

      for (int p = 0; p < 3; p++)
         check($sformatf("pending port %0d", p), q[p].size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
